// File: rtl/decoder_38.sv
// decoder_38 -- 3-to-8 one-hot decoder behind a 2-entry ready/valid FIFO.
//
// Each accepted {en, code} pair is queued. The head entry is presented on vec
// as a one-hot vector, or as all zeros when its enable bit was clear. There is
// no bypass path in either direction. in_ready depends only on the registered
// level and on rst. out_valid depends only on the registered level.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset; empties the FIFO at once
//   in_valid   in   upstream offers {en, code}
//   in_ready   out  FIFO has space (level != 2) and not in reset
//   code[2:0]  in   binary index to decode
//   en         in   decode enable, stored with code
//   out_valid  out  FIFO not empty
//   out_ready  in   downstream takes the head entry
//   vec[7:0]   out  one-hot decode of the head entry (zero if en=0 or empty)
//   level[1:0] out  FIFO occupancy, 0..2
//   xfer_cnt   out  16-bit count of output handshakes, wraps; present only
//                   when DECODER_38_STAT_EN is defined
//
// Optional feature macro: DECODER_38_STAT_EN

module decoder_38 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  code,
  input  logic        en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  vec,
`ifdef DECODER_38_STAT_EN
  output logic [15:0] xfer_cnt,
`endif
  output logic [1:0]  level
);

  // Storage entry layout: {en, code[2:0]}
  logic [3:0] r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_level;

  logic       w_push;
  logic       w_pop;
  logic [3:0] w_head;

  function automatic logic [7:0] f_decode(input logic [3:0] entry);
    return entry[3] ? (8'h01 << entry[2:0]) : 8'h00;
  endfunction

  assign in_ready  = (r_level != 2'd2) && !rst;
  assign out_valid = (r_level != 2'd0);
  assign level     = r_level;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;
  assign w_head = r_mem[r_rptr];

  // The storage contents do not matter when empty, because vec is gated by
  // out_valid.
  assign vec = out_valid ? f_decode(w_head) : 8'h00;

  // Control state: pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_level <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_level <= r_level + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Data storage is not reset. w_push is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {en, code};
  end

`ifdef DECODER_38_STAT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_xfer_cnt <= 16'h0000;
    else if (w_pop) r_xfer_cnt <= r_xfer_cnt + 16'h0001;
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_decoder_38.sv
// Bench for decoder_38: directed scenarios plus randomized traffic, checked
// against a queue-based model of the FIFO.
module tb_decoder_38;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  code = 3'd0;
  logic        en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  vec;
  logic [1:0]  level;
`ifdef DECODER_38_STAT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit compare_on = 1'b0;

  // Model state: queue of {en, code} in acceptance order, plus a pop count.
  logic [3:0] q[$];
  int unsigned model_pops = 0;

  decoder_38 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .code     (code),
    .en       (en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .vec      (vec),
`ifdef DECODER_38_STAT_EN
    .xfer_cnt (xfer_cnt),
`endif
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] h;
    if (q.size() == 0) return 8'h00;
    h = q[0];
    if (!h[3]) return 8'h00;
    return 8'(1 << h[2:0]);
  endfunction

  // Model update: a pop happens when the model is non-empty and out_ready is
  // high. A push happens when the model is not full and not in reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      model_pops = 0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (q.size() < 2);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) begin
        void'(q.pop_front());
        model_pops++;
      end
      if (do_push) q.push_back({en, code});
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (compare_on) begin
      check("level",     {30'd0, level},     q.size());
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      check("in_ready",  {31'd0, in_ready},  {31'd0, (q.size() != 2) && !rst});
      check("vec",       {24'd0, vec},       {24'd0, model_vec()});
`ifdef DECODER_38_STAT_EN
      check("xfer_cnt",  {16'd0, xfer_cnt},  {16'd0, model_pops[15:0]});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c, input logic e);
    in_valid = 1'b1;
    code     = c;
    en       = e;
  endtask

  initial begin
    int max_level;

    // Reset state
    rst = 1'b1;
    step();
    check("rst_level", {30'd0, level}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_vec", {24'd0, vec}, 32'h00);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    compare_on = 1'b1;

    // Sweep codes 0..7 with en=1 and downstream always ready
    out_ready = 1'b1;
    max_level = 0;
    for (int c = 0; c < 8; c++) begin
      push(3'(c), 1'b1);
      step();
      check("sweep_vec", {24'd0, vec}, 32'd1 << c);
      check("sweep_valid", {31'd0, out_valid}, 32'd1);
      if (int'(level) > max_level) max_level = int'(level);
    end
    check("sweep_max_level", max_level, 32'd1);
    in_valid = 1'b0;
    step();
    check("sweep_drain", {30'd0, level}, 32'd0);

    // Disabled decode: the transfer still happens, but vec is zero
    push(3'd5, 1'b0);
    step();
    in_valid = 1'b0;
    check("dis_valid", {31'd0, out_valid}, 32'd1);
    check("dis_vec", {24'd0, vec}, 32'h00);
    step();
    check("dis_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure: push 3 and 6, then hold, then release
    out_ready = 1'b0;
    push(3'd3, 1'b1);
    step();
    push(3'd6, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_level", {30'd0, level}, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_vec", {24'd0, vec}, 32'h08);
    step();
    check("bp_vec_held", {24'd0, vec}, 32'h08);
    out_ready = 1'b1;
    #1;
    check("bp_rel_vec0", {24'd0, vec}, 32'h08);
    step();
    check("bp_rel_vec1", {24'd0, vec}, 32'h40);
    check("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_rel_empty", {31'd0, out_valid}, 32'd0);

    // Concurrent push and pop at level 1
    out_ready = 1'b0;
    push(3'd2, 1'b1);
    step();
    check("cc_head", {24'd0, vec}, 32'h04);
    push(3'd7, 1'b1);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("cc_level", {30'd0, level}, 32'd1);
    check("cc_vec", {24'd0, vec}, 32'h80);
    step();
    check("cc_drain", {30'd0, level}, 32'd0);

    // Reset asserted mid-cycle with a full FIFO
    out_ready = 1'b0;
    push(3'd1, 1'b1);
    step();
    push(3'd4, 1'b1);
    step();
    in_valid = 1'b0;
    check("mr_full", {30'd0, level}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_vec", {24'd0, vec}, 32'h00);
    check("mr_level", {30'd0, level}, 32'd0);
    check("mr_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    push(3'd1, 1'b1);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("mr_after_vec", {24'd0, vec}, 32'h02);
    step();

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      code      = 3'($urandom_range(7));
      en        = ($urandom_range(7) != 0);
      rst       = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

`ifdef DECODER_38_STAT_EN
    // Counter wrap: 65537 pops give a final count of 1
    compare_on = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("cnt_reset", {16'd0, xfer_cnt}, 32'd0);
    push(3'd0, 1'b1);
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 65536; i++) step();
    in_valid = 1'b0;
    step();
    check("cnt_wrap", {16'd0, xfer_cnt}, 32'h0001);
`endif

    compare_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decoder_38.md
DECODER_38 -- requirements
Module: decoder_38

Interface
REQ-001 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-002 rst  input  1  Reset; asynchronous assert and active-high.
REQ-003 in_valid  input  1  Upstream has a code to transfer.
REQ-004 in_ready  output  1  Block can accept a code this cycle.
REQ-005 code  input  3  Binary index, 0..7.
REQ-006 en  input  1  Decode enable, sampled with code; 0 yields all-zero vector.
REQ-007 out_valid  output  1  vec holds a valid decoded entry.
REQ-008 out_ready  input  1  Downstream accepts vec this cycle.
REQ-009 vec  output  8  One-hot decoded vector; bit[code] set when en=1.
REQ-010 level  output  2  Buffer occupancy, 0..2.

Function
REQ-011 Input handshake: transfer occurs on a rising clk edge with in_valid=1 and in_ready=1; {en, code} is pushed into a 2-entry FIFO.
REQ-012 Output handshake: transfer occurs on a rising clk edge with out_valid=1 and out_ready=1; the head entry is popped.
REQ-013 in_ready = (level != 2) and not rst; combinational from registered state only, never from out_ready (no full-state bypass).
REQ-014 out_valid = (level != 0); registered state only, never from in_valid (no empty-state bypass).
REQ-015 Latency: a code accepted into an empty FIFO appears on vec with out_valid=1 exactly one cycle after the accepting edge.
REQ-016 vec = 8'h01 << code when the head entry has en=1; vec = 8'h00 when the head entry has en=0; vec = 8'h00 when out_valid=0.
REQ-017 Entries leave in acceptance order; no reordering, dropping or duplication.
REQ-018 vec and out_valid hold stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous push and pop at level 1: level stays 1 and the new entry becomes head.
REQ-020 Simultaneous push and pop at level 0: impossible, because out_valid=0 at level 0; the push alone applies and level becomes 1.
REQ-021 At level 2: in_ready=0; a pop takes level to 1; in_ready rises in the following cycle.
REQ-022 level updates to: level + push - pop on each edge; it never exceeds 2 and never underflows.
REQ-023 Write and read pointers are 1 bit each and wrap 1 -> 0.

Reset
REQ-024 While rst=1: level=0, both pointers=0, out_valid=0, vec=8'h00, in_ready=0.
REQ-025 rst asserted mid-transfer discards all buffered entries immediately, with no clock edge required.
REQ-026 The first handshake may occur on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro DECODER_38_STAT_EN, when defined, adds output xfer_cnt (16 bits) counting completed output handshakes.
REQ-028 xfer_cnt resets to 0, increments by 1 per pop, and wraps 16'hFFFF -> 16'h0000.
REQ-029 Without DECODER_38_STAT_EN, the xfer_cnt port and counter are absent and all other behaviour is identical.

Verification
REQ-030 Sweep: codes 0..7 with en=1, out_ready=1 -> vec = 01,02,04,...,80, each one cycle after accept; level never exceeds 1.
REQ-031 Disable: code=5 with en=0 -> out_valid=1 and vec=8'h00 for one transfer.
REQ-032 Backpressure: out_ready=0; push 3 then 6 -> level=2, in_ready=0, vec=8'h08 held; release out_ready -> 8'h08 then 8'h40 on consecutive cycles.
REQ-033 Concurrent: level=1 (head code 2); push code 7 while popping -> level stays 1; next vec=8'h80.
REQ-034 Reset mid-operation: level=2, assert rst between edges -> out_valid=0, vec=8'h00, level=0 immediately; after release, push code 1 -> vec=8'h02.
REQ-035 With DECODER_38_STAT_EN: 65537 pops -> xfer_cnt=16'h0001.
